// File: rtl/ocm_arb_pkg.sv
// ============================================================================
// ocm_arb_pkg : shared types and constants for the on-chip RAM arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ocm_arb_pkg;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

  localparam int MAX_READ_LATENCY = 2;

endpackage

`default_nettype wire

// File: rtl/proyecto3_system_ocm_arbiter_grant.sv
// ============================================================================
// ocm_arb_grant : grant decision for the two-master arbiter
// Option macro  : OCM_ARB_RR_EN (round-robin on ties; fixed m0 priority if undefined)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ocm_arb_grant
  import ocm_arb_pkg::*;
(
  input  logic       req_0_i,
  input  logic       req_1_i,
  input  master_id_t last_grant_i,
  input  logic       reset_req_i,
  output logic       grant_0_o,
  output logic       grant_1_o
);

`ifndef OCM_ARB_RR_EN
  // Fixed priority keeps last_grant in the interface but never consults it.
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant_i;
`endif

  always_comb begin
    grant_0_o = 1'b0;
    grant_1_o = 1'b0;
    if (!reset_req_i) begin
      if (req_0_i && req_1_i) begin
`ifdef OCM_ARB_RR_EN
        if (last_grant_i == M0) grant_1_o = 1'b1;
        else                    grant_0_o = 1'b1;
`else
        grant_0_o = 1'b1;
`endif
      end else begin
        grant_0_o = req_0_i;
        grant_1_o = req_1_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/proyecto3_system_ocm_arbiter.sv
// ============================================================================
// proyecto3_system_ocm_arbiter : two-master Avalon-MM arbiter for the OCM
// Option macro : OCM_ARB_RR_EN (selected inside ocm_arb_grant)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module proyecto3_system_ocm_arbiter
  import ocm_arb_pkg::*;
#(
  parameter  int ADDR_W       = 14,
  parameter  int DATA_W       = 32,
  parameter  int READ_LATENCY = 1,
  localparam int BE_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic       w_req_0, w_req_1, w_grant_0, w_grant_1, w_acc_0, w_acc_1, w_block;
  master_id_t last_grant_q, last_grant_d;
  rd_tag_t    tag_d, w_tag_out;
  rd_tag_t    tag_q [MAX_READ_LATENCY];
  logic       w_valid_out;

  assign w_req_0 = m0_read | m0_write;
  assign w_req_1 = m1_read | m1_write;
  // An asserted reset stalls both masters just like a reset request.
  assign w_block = reset_req | reset;

  ocm_arb_grant u_grant (
    .req_0_i      (w_req_0),
    .req_1_i      (w_req_1),
    .last_grant_i (last_grant_q),
    .reset_req_i  (w_block),
    .grant_0_o    (w_grant_0),
    .grant_1_o    (w_grant_1)
  );

  assign w_acc_0        = w_req_0 & w_grant_0;
  assign w_acc_1        = w_req_1 & w_grant_1;
  assign m0_waitrequest = ~w_acc_0;
  assign m1_waitrequest = ~w_acc_1;
  assign mem_clken      = ~reset_req;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    tag_d          = '0;
    last_grant_d   = last_grant_q;
    if (w_acc_0) begin
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      tag_d.valid    = m0_read & ~m0_write;
      tag_d.id       = M0;
      last_grant_d   = M0;
    end else if (w_acc_1) begin
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      tag_d.valid    = m1_read & ~m1_write;
      tag_d.id       = M1;
      last_grant_d   = M1;
    end
  end

  // The tag pipeline freezes alongside the RAM while mem_clken is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= M1;
      for (int k = 0; k < MAX_READ_LATENCY; k++) tag_q[k] <= '0;
    end else if (!reset_req) begin
      last_grant_q <= last_grant_d;
      tag_q[0]     <= tag_d;
      for (int k = 1; k < MAX_READ_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // A frozen tail entry is delivered once, in the first cycle after release.
  assign w_tag_out   = tag_q[READ_LATENCY-1];
  assign w_valid_out = w_tag_out.valid & ~reset_req;

  assign m0_readdatavalid = w_valid_out & (w_tag_out.id == M0);
  assign m1_readdatavalid = w_valid_out & (w_tag_out.id == M1);
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_proyecto3_system_ocm_arbiter.sv
// ============================================================================
// tb_proyecto3_system_ocm_arbiter : directed bench with read scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_proyecto3_system_ocm_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [13:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        mem_chipselect, mem_write, mem_clken;

  proyecto3_system_ocm_arbiter #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM model with registered output: two cycles from address to q.
  logic [31:0] ram [0:16383];
  logic [31:0] q1, q2;
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      q1 <= ram[mem_address];
      q2 <= q1;
    end
  end
  assign mem_readdata = q2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        m;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] d);
    exp_t x;
    x.m = m; x.d = d; x.c = cyc + RL;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", sb.size(), 0);
  endtask

  // Scoreboard consumer: every readdatavalid must match the oldest expected read.
  always @(negedge clk) begin
    if (!reset && (m0_readdatavalid || m1_readdatavalid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 0);
      end else begin
        e = sb.pop_front();
        chk("rdv_master", {30'b0, m1_readdatavalid, m0_readdatavalid}, e.m ? 32'd2 : 32'd1);
        chk("rdv_data", e.m ? m1_readdata : m0_readdata, e.d);
        chk("rdv_other_zero", e.m ? m0_readdata : m1_readdata, 0);
        chk("rdv_latency", cyc, e.c);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    ram[14'h0010] = 32'hDEADBEEF;
    ram[14'h0020] = 32'h12345678;
    ram[14'h3FFF] = 32'hAABBCCDD;
    q1 = '0; q2 = '0;
    idle();
    reset = 1; reset_req = 0;
    m0_read = 1; m0_address = 14'h0010;

    // Reset state with a pending request
    @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
    chk("rst_rdata", m0_readdata | m1_readdata, 0);
    step(); reset = 0; idle();
    @(negedge clk);
    chk("idle_cs", mem_chipselect, 0);
    chk("idle_addr_be_wd", {mem_address, mem_byteenable, mem_write} | mem_writedata, 0);
    chk("idle_clken", mem_clken, 1);

    // Single read by m0
    step(); m0_read = 1; m0_address = 14'h0010;
    @(negedge clk);
    chk("rd_m0_wait", m0_waitrequest, 0);
    chk("rd_cs", mem_chipselect, 1);
    chk("rd_addr", mem_address, 14'h0010);
    chk("rd_mem_write", mem_write, 0);
    push(1'b0, 32'hDEADBEEF);
    step(); idle();
    drain();

    // Read and write together: handled as a write, no read data returned
    step(); m0_read = 1; m0_write = 1; m0_address = 14'h0030; m0_writedata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_mem_write", mem_write, 1);
    chk("rw_wdata", mem_writedata, 32'hCAFEF00D);
    step(); idle(); m0_read = 1; m0_address = 14'h0030;
    @(negedge clk);
    chk("rw_rb_wait", m0_waitrequest, 0);
    push(1'b0, 32'hCAFEF00D);
    step(); idle();
    drain();

    // Byte write by m1 at the top address, then read back
    step(); m1_write = 1; m1_address = 14'h3FFF; m1_byteenable = 4'b0101; m1_writedata = 32'h11223344;
    @(negedge clk);
    chk("bw_m1_wait", m1_waitrequest, 0);
    chk("bw_m0_wait", m0_waitrequest, 1);
    chk("bw_mem_write", mem_write, 1);
    chk("bw_be", mem_byteenable, 4'b0101);
    chk("bw_addr", mem_address, 14'h3FFF);
    chk("bw_wdata", mem_writedata, 32'h11223344);
    step(); idle(); m1_read = 1; m1_address = 14'h3FFF;
    @(negedge clk);
    chk("bw_rd_wait", m1_waitrequest, 0);
    push(1'b1, 32'hAA22CC44);
    step(); idle();
    drain();

    // Contention: both masters request for 4 cycles (last grant is m1 here)
    step(); m0_read = 1; m0_address = 14'h0010; m1_read = 1; m1_address = 14'h0020;
    for (int k = 0; k < 4; k++) begin
      logic g0;
`ifdef OCM_ARB_RR_EN
      g0 = (k % 2 == 0);
`else
      g0 = 1'b1;
`endif
      @(negedge clk);
      chk($sformatf("cont_m0_wait_%0d", k), m0_waitrequest, !g0);
      chk($sformatf("cont_m1_wait_%0d", k), m1_waitrequest, g0);
      chk($sformatf("cont_addr_%0d", k), mem_address, g0 ? 14'h0010 : 14'h0020);
      push(!g0, g0 ? 32'hDEADBEEF : 32'h12345678);
      step();
    end
    idle();
    drain();

    // reset_req held for 3 cycles while m0 requests
    step(); reset_req = 1; m0_read = 1; m0_address = 14'h0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rreq_clken_%0d", k), mem_clken, 0);
      chk($sformatf("rreq_wait_%0d", k), m0_waitrequest, 1);
      chk($sformatf("rreq_cs_%0d", k), mem_chipselect, 0);
      step();
    end
    reset_req = 0;
    @(negedge clk);
    chk("rreq_rel_wait", m0_waitrequest, 0);
    chk("rreq_rel_clken", mem_clken, 1);
    push(1'b0, 32'hDEADBEEF);
    step(); idle();
    drain();

    // Reset one cycle after a read is accepted: no read data may appear
    step(); m0_read = 1; m0_address = 14'h0010;
    @(negedge clk);
    chk("mr_acc_wait", m0_waitrequest, 0);
    step(); idle(); reset = 1;
    @(negedge clk);
    chk("mr_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
    chk("mr_rdata", m0_readdata | m1_readdata, 0);
    chk("mr_cs", mem_chipselect, 0);
    step(); m0_read = 1; m1_read = 1;
    @(negedge clk);
    chk("mr_waits", {m1_waitrequest, m0_waitrequest}, 2'b11);
    step(); reset = 0; idle();
    repeat (4) @(posedge clk);
    #1; m0_read = 1; m0_address = 14'h0010; m1_read = 1; m1_address = 14'h0020;
    @(negedge clk);
    chk("mr_tie_m0_wait", m0_waitrequest, 0);
    chk("mr_tie_m1_wait", m1_waitrequest, 1);
    push(1'b0, 32'hDEADBEEF);
    step(); idle();
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
